mem_req_queue: RTL
==================

// Module: mem_req_queue
// PURPOSE
//  Core-side load/store request queue directly upstream of the dummy memory model.
//  Accepts core requests and tags each with an ID equal to its slot index. Issues requests
//  to memory in order. Matches read responses back by ID and returns load data to the core
//  in program order. Stores retire once issued; memory returns no response for writes.
// PARAMETERS
//  ADDR_WIDTH    32  address width
//  LINE_WIDTH    32  data width
//  CREG_ID_BITS  4   ID width; queue depth DEPTH = 2**CREG_ID_BITS (16)
// PORTS
//  clk           in   1           clock, all state on posedge
//  reset         in   1           synchronous, active-low reset
//  req_valid     in   1           core request valid
//  req_ready     out  1           queue can accept (count < DEPTH)
//  req_rw        in   1           1 = store, 0 = load
//  req_addr      in   ADDR_WIDTH  request address
//  req_data      in   LINE_WIDTH  store data
//  rsp_valid     out  1           head load data valid
//  rsp_ready     in   1           core accepts load data
//  rsp_data      out  LINE_WIDTH  load data
//  rsp_addr      out  ADDR_WIDTH  address of returned load
//  mem_valid     out  1           request to memory valid
//  mem_rw        out  1           1 = write
//  mem_addr      out  ADDR_WIDTH  memory address
//  mem_data      out  LINE_WIDTH  memory write data
//  mem_id        out  CREG_ID_BITS slot ID of issued request
//  mem_stall     in   1           memory cannot accept a request this cycle
//  mem_ready_in  in   1           memory read response valid
//  mem_id_in     in   CREG_ID_BITS ID of response
//  mem_data_in   in   LINE_WIDTH  response data
//  count         out  CREG_ID_BITS+1 occupied entries
//  err_rsp       out  1           sticky: unexpected response seen
// BEHAVIOUR
//  - Pointers: tail (alloc), iss (issue), head (retire). Each is CREG_ID_BITS wide and wraps modulo DEPTH.
//  - Entry states: FREE -> WAIT_ISS -> (load: WAIT_DATA | store: DONE) -> DONE -> FREE.
//  - Alloc: req_valid & req_ready writes {rw, addr, data} to slot[tail] as WAIT_ISS; tail++.
//  - req_ready = (count != DEPTH), based on the registered count only. A retire in the same
//    cycle does not free a slot for a same-cycle alloc.
//  - Issue: combinational from slot[iss]. mem_valid = (slot[iss]==WAIT_ISS) & ~mem_stall.
//    mem_id = iss. On mem_valid, iss++ and the slot moves to WAIT_DATA (load) or DONE (store).
//  - Issue is strictly in order: at most one issue per cycle. An accepted request issues no
//    earlier than the following cycle.
//  - Response: mem_ready_in with slot[mem_id_in]==WAIT_DATA captures mem_data_in and sets the
//    slot to DONE. Any other state sets err_rsp and leaves the slot unchanged.
//  - Retire, at most one per cycle, head slot only:
//    - DONE store: freed silently.
//    - DONE load: rsp_valid=1 with its data/addr; freed when rsp_ready.
//    - head++ on free.
//  - count: +1 on alloc, -1 on retire. Simultaneous alloc and retire leaves count unchanged.
//  - Response, issue, alloc and retire on different slots in the same cycle all take effect.
//  - Reset (sync, reset==0): all slots FREE, pointers 0, count 0, err_rsp 0.
//    All outputs read 0 except req_ready=1.
//  - Reset mid-operation drops all in-flight entries. Responses arriving after reset hit FREE
//    slots and set err_rsp.
// CONFIGURATION
//  MEMQ_RSP_BYPASS_EN defined:
//   - A response whose ID matches a head load in WAIT_DATA drives rsp_valid/rsp_data in the
//     same cycle from mem_data_in.
//   - If rsp_ready, the slot frees that cycle without entering DONE.
//  MEMQ_RSP_BYPASS_EN undefined: rsp_valid rises the cycle after the response is captured.
// TESTING
//  1 Reset then idle -> req_ready=1, mem_valid=0, rsp_valid=0, count=0, err_rsp=0.
//  2 Load A=0x40 at cycle 0 -> mem_valid,rw=0,id=0 at cycle 1. Respond id=0, data=0xDEAD ->
//    rsp_valid at next cycle (same cycle with bypass), rsp_data=0xDEAD, count returns to 0.
//  3 Store 0x80/0x1234 then load 0x80 -> store issues id=0 and retires without response.
//    Load issues id=1; rsp only after mem_ready_in with id=1.
//  4 Loads L0..L2 issued; responses arrive in order id2,id0,id1 -> rsp returns L0,L1,L2 in order.
//  5 Fill 16 entries, mem_stall=1 -> req_ready=0 at count=16, mem_valid=0. Drop the stall ->
//    issues id 0..15 over 16 cycles. Pointers wrap; a 17th request gets id=0.
//  6 mem_ready_in with id=5 while slot 5 is FREE -> err_rsp=1 and sticky; queue unaffected.
//    Assert reset mid-stream -> all state cleared and err_rsp=0.

Source files
------------

// File: rtl/mem_req_queue.sv
// mem_req_queue -- in-order load/store request queue feeding the memory model.
//
// Core requests are allocated into a circular buffer of DEPTH = 2**CREG_ID_BITS
// slots. The slot index is the request ID. Requests go to memory strictly in
// order. Read responses come back by ID, in any order. Load data is returned
// to the core in program order. Stores retire as soon as they have issued.
//
// Optional feature macro: MEMQ_RSP_BYPASS_EN
//   When defined, a read response for the head load is forwarded to the core
//   in the same cycle it arrives. If the core accepts it, the slot frees
//   without passing through DONE.
//
// Ports
//   i_clk, i_reset          clock; synchronous active-low reset
//   i_req_*, o_req_ready    core request (rw: 1 = store)
//   o_rsp_*, i_rsp_ready    in-order load data back to the core
//   o_mem_*, i_mem_stall    request issue to memory; o_mem_id = slot index
//   i_mem_ready_in/_id_in/_data_in   read response from memory
//   o_count                 occupied slots
//   o_err_rsp               sticky: response hit a slot not waiting for data
module mem_req_queue #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 32,
  parameter int CREG_ID_BITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_rw,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [LINE_WIDTH-1:0]   i_req_data,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [LINE_WIDTH-1:0]   o_rsp_data,
  output logic [ADDR_WIDTH-1:0]   o_rsp_addr,
  output logic                    o_mem_valid,
  output logic                    o_mem_rw,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [LINE_WIDTH-1:0]   o_mem_data,
  output logic [CREG_ID_BITS-1:0] o_mem_id,
  input  logic                    i_mem_stall,
  input  logic                    i_mem_ready_in,
  input  logic [CREG_ID_BITS-1:0] i_mem_id_in,
  input  logic [LINE_WIDTH-1:0]   i_mem_data_in,
  output logic [CREG_ID_BITS:0]   o_count,
  output logic                    o_err_rsp
);

  localparam int DEPTH = 1 << CREG_ID_BITS;
  localparam logic [CREG_ID_BITS:0] FULL = {1'b1, {CREG_ID_BITS{1'b0}}};

  typedef enum logic [1:0] {S_FREE, S_WAIT_ISS, S_WAIT_DATA, S_DONE} st_e;

  st_e                    r_st   [DEPTH];
  logic                   r_rw   [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_addr [DEPTH];
  logic [LINE_WIDTH-1:0]  r_data [DEPTH];

  logic [CREG_ID_BITS-1:0] r_tail, r_iss, r_head;
  logic [CREG_ID_BITS:0]   r_count;
  logic                    r_err;

  logic w_req_ready, w_alloc, w_issue, w_rsp_hit;
  logic w_head_done, w_done_ld, w_byp, w_rsp_valid, w_retire;

  // Full is judged on the registered count only: a same-cycle retire does
  // not open a slot for a same-cycle alloc.
  assign w_req_ready = (r_count != FULL);
  assign w_alloc     = i_req_valid & w_req_ready;
  assign w_issue     = (r_st[r_iss] == S_WAIT_ISS) & ~i_mem_stall;
  assign w_rsp_hit   = i_mem_ready_in & (r_st[i_mem_id_in] == S_WAIT_DATA);
  assign w_head_done = (r_st[r_head] == S_DONE);
  assign w_done_ld   = w_head_done & ~r_rw[r_head];

`ifdef MEMQ_RSP_BYPASS_EN
  // Only loads ever sit in WAIT_DATA, so a hit on the head is a head load.
  assign w_byp = w_rsp_hit & (i_mem_id_in == r_head);
`else
  assign w_byp = 1'b0;
`endif

  assign w_rsp_valid = w_done_ld | w_byp;
  // Stores at the head leave silently; loads wait for the core.
  assign w_retire    = (w_head_done & r_rw[r_head]) | (w_rsp_valid & i_rsp_ready);

  // Payload outputs are zeroed when not valid so idle/reset reads are clean.
  assign o_req_ready = w_req_ready;
  assign o_mem_valid = w_issue;
  assign o_mem_rw    = w_issue & r_rw[r_iss];
  assign o_mem_addr  = w_issue ? r_addr[r_iss] : '0;
  assign o_mem_data  = (w_issue & r_rw[r_iss]) ? r_data[r_iss] : '0;
  assign o_mem_id    = r_iss;
  assign o_rsp_valid = w_rsp_valid;
  assign o_rsp_data  = w_byp ? i_mem_data_in : (w_done_ld ? r_data[r_head] : '0);
  assign o_rsp_addr  = w_rsp_valid ? r_addr[r_head] : '0;
  assign o_count     = r_count;
  assign o_err_rsp   = r_err;

  // Slot state and pointers. Response, issue, retire and alloc always target
  // different slots except bypass-retire of the responding slot; retire is
  // written after the response so that case ends FREE.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_st[i] <= S_FREE;
      r_tail  <= '0;
      r_iss   <= '0;
      r_head  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (i_mem_ready_in) begin
        if (w_rsp_hit) r_st[i_mem_id_in] <= S_DONE;
        else           r_err             <= 1'b1;
      end
      if (w_issue) begin
        r_st[r_iss] <= r_rw[r_iss] ? S_DONE : S_WAIT_DATA;
        r_iss       <= r_iss + 1'b1;
      end
      if (w_retire) begin
        r_st[r_head] <= S_FREE;
        r_head       <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_st[r_tail] <= S_WAIT_ISS;
        r_tail       <= r_tail + 1'b1;
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; slot state decides whether it is live.
  always_ff @(posedge i_clk) begin
    if (w_alloc) begin
      r_rw[r_tail]   <= i_req_rw;
      r_addr[r_tail] <= i_req_addr;
      r_data[r_tail] <= i_req_data;
    end
    if (w_rsp_hit) r_data[i_mem_id_in] <= i_mem_data_in;
  end

endmodule
